// File: rtl/gmii_rx_frame_check.sv
// GMII receive framing: preamble/SFD detection, nibble-to-byte assembly,
// CRC-32 and length checking, FCS removal and good/bad frame statistics.
module gmii_rx_frame_check #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int CNT_W   = 16
) (
    input  logic             rx_rgmii_clk,
    input  logic             rx_reset,
    input  logic             speed_10_100,
    input  logic [7:0]       gmii_rxd,
    input  logic             gmii_rx_dv,
    input  logic             gmii_rx_er,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             rx_sof,
    output logic             rx_last,
    output logic             rx_err,
    output logic [CNT_W-1:0] good_frame_cnt,
    output logic [CNT_W-1:0] bad_frame_cnt
);

    localparam int LEN_W = $clog2(MAX_LEN + 2);
    localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] MIN_L   = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);
    // 0xC704DD7B expressed in the bit-reflected (shift-right) register order
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {
        DROP     = 2'd0,
        IDLE     = 2'd1,
        PREAMBLE = 2'd2,
        DATA     = 2'd3
    } state_t;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int unsigned i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    // Stage 0: input registers
    logic [7:0] rxd_q;
    logic       dv_q;
    logic       er_q;

    always_ff @(posedge rx_rgmii_clk or posedge rx_reset) begin
        if (rx_reset) begin
            rxd_q <= '0;
            dv_q  <= 1'b0;
            er_q  <= 1'b0;
        end else begin
            rxd_q <= gmii_rxd;
            dv_q  <= gmii_rx_dv;
            er_q  <= gmii_rx_er;
        end
    end

    // Stage 1: framing FSM and byte assembly
    state_t     state, state_nx;
    logic       sfd;
    logic       primed;
    logic       nib_mode;
    logic       nib_phase;
    logic [3:0] nib_lo;
    logic       er_seen;
    logic       b_valid;
    logic [7:0] b_data;
    logic       b_eof;
    logic       b_odd;
    logic       b_er;

    always_comb begin
        state_nx = state;
        sfd      = 1'b0;
        case (state)
            DROP: begin
                // primed holds DROP for the first sample after reset, which
                // still carries the cleared dv rather than the line state
                if (!dv_q && primed) state_nx = IDLE;
            end
            IDLE: begin
                if (dv_q) begin
                    if (speed_10_100) begin
                        state_nx = (rxd_q[3:0] == 4'h5) ? PREAMBLE : DROP;
                    end else if (rxd_q == 8'h55) begin
                        state_nx = PREAMBLE;
                    end else if (rxd_q == 8'hD5) begin
                        state_nx = DATA;
                        sfd      = 1'b1;
                    end else begin
                        state_nx = DROP;
                    end
                end
            end
            PREAMBLE: begin
                if (!dv_q) begin
                    state_nx = IDLE;
                end else if (speed_10_100) begin
                    if (rxd_q[3:0] == 4'hD) begin
                        state_nx = DATA;
                        sfd      = 1'b1;
                    end else if (rxd_q[3:0] != 4'h5) begin
                        state_nx = DROP;
                    end
                end else begin
                    if (rxd_q == 8'hD5) begin
                        state_nx = DATA;
                        sfd      = 1'b1;
                    end else if (rxd_q != 8'h55) begin
                        state_nx = DROP;
                    end
                end
            end
            DATA: begin
                if (!dv_q) state_nx = IDLE;
            end
            default: state_nx = DROP;
        endcase
    end

    always_ff @(posedge rx_rgmii_clk or posedge rx_reset) begin
        if (rx_reset) begin
            state     <= DROP;
            primed    <= 1'b0;
            nib_mode  <= 1'b0;
            nib_phase <= 1'b0;
            nib_lo    <= '0;
            er_seen   <= 1'b0;
            b_valid   <= 1'b0;
            b_data    <= '0;
            b_eof     <= 1'b0;
            b_odd     <= 1'b0;
            b_er      <= 1'b0;
        end else begin
            state   <= state_nx;
            primed  <= 1'b1;
            b_valid <= 1'b0;
            b_eof   <= 1'b0;
            if (sfd) begin
                nib_mode  <= speed_10_100;
                nib_phase <= 1'b0;
                er_seen   <= 1'b0;
            end
            if (state == DATA) begin
                if (dv_q) begin
                    if (er_q) er_seen <= 1'b1;
                    if (nib_mode) begin
                        nib_phase <= ~nib_phase;
                        if (!nib_phase) begin
                            nib_lo <= rxd_q[3:0];
                        end else begin
                            b_valid <= 1'b1;
                            b_data  <= {rxd_q[3:0], nib_lo};
                        end
                    end else begin
                        b_valid <= 1'b1;
                        b_data  <= rxd_q;
                    end
                end else begin
                    b_eof <= 1'b1;
                    b_odd <= nib_mode & nib_phase;
                    b_er  <= er_seen;
                end
            end
        end
    end

    // Stage 2: FCS strip delay line, CRC/length check, output and counters
    logic [7:0]       sr [5];
    logic [2:0]       held;
    logic [31:0]      crc_n;
    logic [LEN_W-1:0] len;
    logic             sof_done;
    logic             inc_good;
    logic             inc_bad;
    logic [31:0]      crc_cur;
    logic             frame_bad;

    // CRC is held inverted so the all-zero reset value is the 0xFFFFFFFF seed
    always_comb begin
        crc_cur   = ~crc_n;
        frame_bad = (crc_cur != CRC_RESIDUE) || (len < MIN_L) || (len > MAX_L) || b_er || b_odd;
    end

    always_ff @(posedge rx_rgmii_clk or posedge rx_reset) begin
        if (rx_reset) begin
            for (int unsigned i = 0; i < 5; i++) sr[i] <= '0;
            held           <= '0;
            crc_n          <= '0;
            len            <= '0;
            sof_done       <= 1'b0;
            inc_good       <= 1'b0;
            inc_bad        <= 1'b0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
            rx_sof         <= 1'b0;
            rx_last        <= 1'b0;
            rx_err         <= 1'b0;
            good_frame_cnt <= '0;
            bad_frame_cnt  <= '0;
        end else begin
            rx_valid <= 1'b0;
            rx_sof   <= 1'b0;
            rx_last  <= 1'b0;
            rx_err   <= 1'b0;
            inc_good <= 1'b0;
            inc_bad  <= 1'b0;
            if (inc_good) good_frame_cnt <= good_frame_cnt + 1'b1;
            if (inc_bad)  bad_frame_cnt  <= bad_frame_cnt + 1'b1;
            if (b_valid) begin
                sr[0] <= b_data;
                for (int unsigned i = 1; i < 5; i++) sr[i] <= sr[i-1];
                crc_n <= ~crc_step(crc_cur, b_data);
                if (len != LEN_SAT) len <= len + 1'b1;
                if (held == 3'd5) begin
                    rx_valid <= 1'b1;
                    rx_data  <= sr[4];
                    rx_sof   <= ~sof_done;
                    sof_done <= 1'b1;
                end else begin
                    held <= held + 1'b1;
                end
            end else if (b_eof) begin
                if (held == 3'd5) begin
                    rx_valid <= 1'b1;
                    rx_data  <= sr[4];
                    rx_sof   <= ~sof_done;
                    rx_last  <= 1'b1;
                    rx_err   <= frame_bad;
                end
                inc_good <= (held == 3'd5) && !frame_bad;
                inc_bad  <= (held != 3'd5) || frame_bad;
                held     <= '0;
                crc_n    <= '0;
                len      <= '0;
                sof_done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gmii_rx_frame_check.sv
// Randomized scoreboard bench for gmii_rx_frame_check: a frame-level model
// predicts the emitted byte stream and counters; a monitor checks each beat.
module tb_gmii_rx_frame_check;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spd = 1'b0;
    logic [7:0]  rxd = '0;
    logic        dv  = 1'b0;
    logic        er  = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_sof, rx_last, rx_err;
    logic [15:0] good_cnt, bad_cnt;

    always #4 clk = ~clk;

    gmii_rx_frame_check #(.MIN_LEN(64), .MAX_LEN(1518), .CNT_W(16)) dut (
        .rx_rgmii_clk   (clk),
        .rx_reset       (rst),
        .speed_10_100   (spd),
        .gmii_rxd       (rxd),
        .gmii_rx_dv     (dv),
        .gmii_rx_er     (er),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_sof         (rx_sof),
        .rx_last        (rx_last),
        .rx_err         (rx_err),
        .good_frame_cnt (good_cnt),
        .bad_frame_cnt  (bad_cnt)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       last;
        logic       err;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] frm[$];
    int         checks = 0;
    int         failures = 0;
    int         exp_good = 0;
    int         exp_bad = 0;

    // Ethernet FCS of frm[0..n-1], as transmitted (final complement applied)
    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, frm[i]};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic build(input int n_payload, input bit seq, input bit bad_fcs);
        logic [31:0] f;
        frm.delete();
        for (int i = 0; i < n_payload; i++) frm.push_back(seq ? 8'(i) : 8'($urandom));
        f = fcs_of(n_payload);
        if (bad_fcs) f[7:0] = ~f[7:0];
        for (int i = 0; i < 4; i++) frm.push_back(f[8*i +: 8]);
    endtask

    task automatic expect_frame(input bit odd, input bit er_hit);
        int n;
        bit fcs_ok, err;
        beat_t b;
        n = frm.size();
        fcs_ok = (n >= 4) && (fcs_of(n - 4) == {frm[n-1], frm[n-2], frm[n-3], frm[n-4]});
        err = !fcs_ok || (n < 64) || (n > 1518) || odd || er_hit;
        if (n >= 5) begin
            for (int k = 0; k <= n - 5; k++) begin
                b.data = frm[k];
                b.sof  = (k == 0);
                b.last = (k == n - 5);
                b.err  = (k == n - 5) ? err : 1'b0;
                exp_q.push_back(b);
            end
        end
        if (n < 5 || err) exp_bad++;
        else exp_good++;
    endtask

    task automatic cyc(input logic [7:0] b, input logic v, input logic e);
        rxd = b;
        dv  = v;
        er  = e;
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string tag);
        checks++;
        if (good_cnt !== 16'(exp_good) || bad_cnt !== 16'(exp_bad)) begin
            failures++;
            $display("FAIL %s counters: got good=%0d bad=%0d, want good=%0d bad=%0d",
                     tag, good_cnt, bad_cnt, exp_good, exp_bad);
        end
    endtask

    task automatic send_frame(input bit nib, input bit extra, input int er_at,
                              input int rst_at, input int gap, input bit chk, input string tag);
        spd = nib;
        if (nib) begin
            repeat (15) cyc({4'($urandom), 4'h5}, 1'b1, 1'b0);
            cyc({4'($urandom), 4'hD}, 1'b1, 1'b0);
        end else begin
            repeat (7) cyc(8'h55, 1'b1, 1'b0);
            cyc(8'hD5, 1'b1, 1'b0);
        end
        for (int k = 0; k < frm.size(); k++) begin
            if (k == rst_at) begin
                rst = 1'b1;
                exp_q.delete();
                exp_good = 0;
                exp_bad  = 0;
            end
            if (k == rst_at + 2) rst = 1'b0;
            if (nib) begin
                cyc({4'($urandom), frm[k][3:0]}, 1'b1, k == er_at);
                cyc({4'($urandom), frm[k][7:4]}, 1'b1, 1'b0);
            end else begin
                cyc(frm[k], 1'b1, k == er_at);
            end
        end
        if (extra) cyc({4'($urandom), 4'($urandom)}, 1'b1, 1'b0);
        repeat (gap) cyc(8'($urandom), 1'b0, 1'b0);
        if (chk) begin
            repeat (5) cyc(8'h00, 1'b0, 1'b0);
            check_counts(tag);
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge
    initial begin
        beat_t want, got;
        forever begin
            @(negedge clk);
            if (rx_valid) begin
                checks++;
                got = {rx_data, rx_sof, rx_last, rx_err};
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat: got data=%02h sof=%0b last=%0b err=%0b, want no output",
                             rx_data, rx_sof, rx_last, rx_err);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        failures++;
                        $display("FAIL beat: got data=%02h sof=%0b last=%0b err=%0b, want data=%02h sof=%0b last=%0b err=%0b",
                                 got.data, got.sof, got.last, got.err,
                                 want.data, want.sof, want.last, want.err);
                    end
                end
            end else if (rx_sof || rx_last || rx_err) begin
                checks++;
                failures++;
                $display("FAIL stray_flag: got sof=%0b last=%0b err=%0b with rx_valid=0, want all 0",
                         rx_sof, rx_last, rx_err);
            end
        end
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        bit nib, bad, extra, erf;
        int n;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rx_data, rx_valid, rx_sof, rx_last, rx_err, good_cnt, bad_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_state: got data=%02h valid=%0b good=%0d bad=%0d, want all 0",
                     rx_data, rx_valid, good_cnt, bad_cnt);
        end
        rst = 1'b0;
        repeat (3) cyc(8'h00, 1'b0, 1'b0);

        build(60, 1'b1, 1'b0); expect_frame(1'b0, 1'b0); send_frame(1'b0, 1'b0, -1, -1, 2, 1'b1, "byte_good");
        build(60, 1'b1, 1'b1); expect_frame(1'b0, 1'b0); send_frame(1'b0, 1'b0, -1, -1, 2, 1'b1, "byte_bad_fcs");
        build(60, 1'b1, 1'b0); expect_frame(1'b0, 1'b0); send_frame(1'b1, 1'b0, -1, -1, 2, 1'b1, "nib_good");
        build(60, 1'b1, 1'b0); expect_frame(1'b1, 1'b0); send_frame(1'b1, 1'b1, -1, -1, 2, 1'b1, "nib_odd");
        build(60, 1'b0, 1'b0); expect_frame(1'b0, 1'b1); send_frame(1'b0, 1'b0, 20, -1, 2, 1'b1, "rx_er");
        build(0, 1'b0, 1'b0);  expect_frame(1'b0, 1'b0); send_frame(1'b0, 1'b0, -1, -1, 2, 1'b1, "runt");
        build(1, 1'b0, 1'b0);  expect_frame(1'b0, 1'b0); send_frame(1'b0, 1'b0, -1, -1, 2, 1'b1, "five_bytes");
        build(59, 1'b0, 1'b0); expect_frame(1'b0, 1'b0); send_frame(1'b0, 1'b0, -1, -1, 2, 1'b1, "len63");
        build(1515, 1'b0, 1'b0); expect_frame(1'b0, 1'b0); send_frame(1'b0, 1'b0, -1, -1, 2, 1'b1, "len1519");
        build(1514, 1'b0, 1'b0); expect_frame(1'b0, 1'b0); send_frame(1'b0, 1'b0, -1, -1, 2, 1'b1, "len1518");

        build(60, 1'b0, 1'b0); expect_frame(1'b0, 1'b0); send_frame(1'b0, 1'b0, -1, 30, 2, 1'b1, "mid_reset");
        build(60, 1'b1, 1'b0); expect_frame(1'b0, 1'b0); send_frame(1'b0, 1'b0, -1, -1, 2, 1'b1, "after_reset");

        build(60, 1'b0, 1'b0); expect_frame(1'b0, 1'b0); send_frame(1'b0, 1'b0, -1, -1, 1, 1'b0, "b2b_a");
        build(70, 1'b0, 1'b0); expect_frame(1'b0, 1'b0); send_frame(1'b0, 1'b0, -1, -1, 1, 1'b1, "b2b_b");

        for (int i = 0; i < 10; i++) begin
            nib   = 1'($urandom);
            bad   = ($urandom_range(0, 3) == 0);
            extra = nib && ($urandom_range(0, 3) == 0);
            erf   = ($urandom_range(0, 7) == 0);
            n     = $urandom_range(1, 90);
            build(n, 1'b0, bad);
            expect_frame(extra, erf);
            send_frame(nib, extra, erf ? $urandom_range(0, n - 1) : -1, -1, $urandom_range(1, 3), 1'b1, "random");
        end

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d beats never emitted, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gmii_rx_frame_check.md
Name: gmii_rx_frame_check

Overview:
- Receive-side framing stage directly downstream of the RGMII interface, in the rx_rgmii_clk domain.
- Consumes GMII receive signals (gmii_rxd, gmii_rx_dv, gmii_rx_er) and assembles 10/100 nibbles into bytes.
- Detects preamble/SFD, checks CRC-32 and length, and strips the FCS.
- Presents a byte stream with frame delimiters and error status to the MAC receive logic, and maintains good/bad frame counters.

Parameters:
MIN_LEN, 64, minimum legal frame length in bytes, FCS included
MAX_LEN, 1518, maximum legal frame length in bytes, FCS included
CNT_W, 16, width of frame statistics counters

Ports:
rx_rgmii_clk  input  1  receive clock (125/25/2.5 MHz)
rx_reset  input  1  asynchronous, active-high reset
speed_10_100  input  1  1 = nibble mode (only gmii_rxd[3:0] valid per cycle); 0 = byte mode
gmii_rxd  input  8  GMII receive data
gmii_rx_dv  input  1  GMII receive data valid
gmii_rx_er  input  1  GMII receive error
rx_data  output  8  frame byte, FCS removed
rx_valid  output  1  rx_data valid; no backpressure
rx_sof  output  1  first payload byte (first byte after SFD)
rx_last  output  1  last byte of frame before FCS
rx_err  output  1  frame error, valid only with rx_last
good_frame_cnt  output  CNT_W  frames ended with rx_err=0
bad_frame_cnt  output  CNT_W  frames ended with rx_err=1, runts included

Behaviour:
- Clock is one clock, rx_rgmii_clk; reset is rx_reset, asynchronous and active-high. Reset clears all outputs, counters, the pipeline and CRC to 0; the FSM resets to DROP.
- Stage 0 registers gmii_rxd, gmii_rx_dv and gmii_rx_er. All processing uses the registered values.
- Byte assembly:
  - Byte mode: every cycle with dv=1 yields one byte.
  - Nibble mode: low nibble arrives first, high nibble second. A byte is produced on every second dv=1 cycle after the SFD; the nibble phase resets to 0 at SFD.
- speed_10_100 is latched at SFD and held for the whole frame.
- FSM states: DROP, IDLE, PREAMBLE, DATA.
  - DROP -> IDLE when dv=0.
  - IDLE, dv=1, byte mode: 0x55 -> PREAMBLE; 0xD5 -> DATA; any other value -> DROP.
  - IDLE, dv=1, nibble mode: 0x5 -> PREAMBLE; any other value -> DROP.
  - PREAMBLE, byte mode: 0x55 stays; 0xD5 -> DATA.
  - PREAMBLE, nibble mode: 0x5 stays; 0xD after 0x5 -> DATA.
  - PREAMBLE: any other value -> DROP; dv=0 -> IDLE. No output and no counting for these cases.
  - DATA: dv=0 -> end-of-frame processing, then IDLE.
- FCS strip: a 5-byte shift register sr[0..4], with sr[4] oldest.
  - When a new byte enters and 5 bytes are held, sr[4] is emitted with rx_valid=1.
  - At end of frame with at least 5 bytes held, sr[4] is emitted with rx_last=1 and rx_err; sr[3:0] is the discarded FCS.
- rx_sof accompanies the first emitted byte of the frame.
- Latency: byte D_k appears on rx_data 2 clocks after the edge sampling D_(k+5). rx_last appears 2 clocks after the first dv=0 sample.
- CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, reflected, LSB first) runs over all bytes after SFD, FCS included. Good when the residue equals 0xC704DD7B.
- Length counter counts bytes after SFD, FCS included, and saturates at MAX_LEN+1.
- rx_err = bad CRC OR length < MIN_LEN OR length > MAX_LEN OR any gmii_rx_er during DATA (sticky) OR odd nibble count (trailing nibble discarded).
- Oversize frames are still forwarded in full; they are flagged only via rx_err.
- Runt (fewer than 5 bytes after SFD): nothing emitted, bad_frame_cnt increments at end of frame.
- Counters increment once per DATA frame end, one clock after rx_last (or runt end), and wrap at 2^CNT_W.
- rx_valid/rx_sof/rx_last/rx_err are single-cycle pulses and are 0 otherwise. rx_data holds its last value when rx_valid=0.
- Reset mid-frame: output stops immediately, with no rx_last and no count. After release, the FSM stays in DROP while dv=1, so the remainder of the interrupted frame is ignored.
- A new frame may begin on the cycle after dv falls; end-of-frame emission of the previous frame must not be lost.

Test Plan:
- Byte mode, preamble 7x0x55 + 0xD5 + 60 bytes 0x00..0x3B + correct FCS -> 60 rx_valid bytes 0x00..0x3B; rx_sof on 0x00; rx_last on 0x3B with rx_err=0; good_frame_cnt=1.
- Same frame with FCS byte 0 inverted -> 60 bytes emitted, rx_last with rx_err=1, bad_frame_cnt=1, good_frame_cnt unchanged.
- Nibble mode: 15x0x5, 0xD, then the same frame as nibbles, low first -> identical 60-byte output and rx_err=0. The same frame with one extra trailing nibble -> rx_err=1.
- Byte mode, 64-byte good frame with gmii_rx_er=1 for one cycle at byte 20 -> rx_last with rx_err=1.
- Runt: SFD + 4 bytes, then dv=0 -> no rx_valid, bad_frame_cnt+1. A 1519-byte frame with valid CRC -> 1515 bytes out, rx_err=1.
- Assert rx_reset at byte 30 of a frame and release while dv=1 -> no output until the next preamble. The next good frame is received correctly with good_frame_cnt=1. Back-to-back frames with a 1-cycle dv gap -> both rx_last pulses are present.
